// File: rtl/ahb_uart_access_sched_pkg.sv
// Shared types and constants for the AHB UART access scheduler: FSM encoding,
// AHB transfer types and status-register bit positions.
package ahb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S_ADDR = 3'd1,
    ST_S_DATA = 3'd2,
    ST_W_ADDR = 3'd3,
    ST_W_DATA = 3'd4,
    ST_ACK    = 3'd5,
    ST_R_ADDR = 3'd6,
    ST_R_DATA = 3'd7
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;

  function automatic logic is_addr_phase(input state_e s);
    return (s == ST_S_ADDR) || (s == ST_W_ADDR) || (s == ST_R_ADDR);
  endfunction

endpackage

// File: rtl/ahb_uart_access_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie;
// after a requester is served the pointer moves to the other one.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o,
  output logic       ptr_o
);

  logic ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (update_i) begin
      ptr_q <= ~served_i;
    end
  end

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = req_i[ptr_q] ? ptr_q : ~ptr_q;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ahb_uart_access_sched.sv
// AHB-Lite master sharing one UART slave between two byte-transmit requesters
// and a receive consumer; polls tx_full before every TX write, reads on uart_irq.
module ahb_uart_access_sched
  import ahb_uart_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR = 32'h5100_0000,
  parameter logic [31:0] STAT_ADDR = 32'h5100_0004,
  parameter int unsigned MAX_POLLS = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  tx_req,
  input  logic [7:0]  tx_byte0,
  input  logic [7:0]  tx_byte1,
  output logic [1:0]  tx_ack,
  output logic        tx_drop,
  input  logic        uart_irq,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic        HREADYOUT,
  input  logic [31:0] HRDATA
);

  localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [7:0]    byte_q, byte_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          drop_q, drop_d;
  logic          rx_valid_q;
  logic [7:0]    rx_byte_q;

  logic arb_valid, arb_idx, arb_ptr;
  logic rr_update;
  logic rx_capture;
  logic tx_busy;
  logic unused_hrdata;

  rr_arb2 u_arb (
    .clk_i         (HCLK),
    .rst_i         (HRESET),
    .req_i         (tx_req),
    .update_i      (rr_update),
    .served_i      (grant_q),
    .grant_valid_o (arb_valid),
    .grant_idx_o   (arb_idx),
    .ptr_o         (arb_ptr)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      byte_q     <= 8'h00;
      poll_q     <= '0;
      drop_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      byte_q     <= byte_d;
      poll_q     <= poll_d;
      drop_q     <= drop_d;
      rx_valid_q <= rx_capture;
      if (rx_capture) begin
        rx_byte_q <= HRDATA[7:0];
      end
    end
  end

  // Only one transfer is ever in flight, so no address phase overlaps a data phase.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    byte_d     = byte_q;
    poll_d     = poll_q;
    drop_d     = drop_q;
    rr_update  = 1'b0;
    rx_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (uart_irq) begin
          state_d = ST_R_ADDR;
        end else if (arb_valid) begin
          grant_d = arb_idx;
          byte_d  = arb_idx ? tx_byte1 : tx_byte0;
          poll_d  = '0;
          drop_d  = 1'b0;
          state_d = ST_S_ADDR;
        end
      end
      ST_S_ADDR: if (HREADYOUT) state_d = ST_S_DATA;
      ST_S_DATA: begin
        if (HREADYOUT) begin
          if (!HRDATA[STAT_TX_FULL]) begin
            state_d = ST_W_ADDR;
          end else if (poll_q != POLL_LAST) begin
            poll_d  = poll_q + 1'b1;
            state_d = ST_S_ADDR;
          end else begin
            drop_d  = 1'b1;
            state_d = ST_ACK;
          end
        end
      end
      ST_W_ADDR: if (HREADYOUT) state_d = ST_W_DATA;
      ST_W_DATA: if (HREADYOUT) state_d = ST_ACK;
      ST_ACK: begin
        rr_update = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_R_ADDR: if (HREADYOUT) state_d = ST_R_DATA;
      ST_R_DATA: begin
        if (HREADYOUT) begin
          rx_capture = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HTRANS  = is_addr_phase(state_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    HSEL    = (HTRANS == HTRANS_NONSEQ);
    HWRITE  = (state_q == ST_W_ADDR);
    HADDR   = 32'h0;
    if (state_q == ST_S_ADDR) begin
      HADDR = STAT_ADDR;
    end else if (state_q == ST_W_ADDR || state_q == ST_R_ADDR) begin
      HADDR = DATA_ADDR;
    end
    HWDATA  = (state_q == ST_W_DATA) ? {24'h0, byte_q} : 32'h0;
    HREADY  = HREADYOUT;
    tx_ack  = 2'b00;
    if (state_q == ST_ACK) begin
      tx_ack[grant_q] = 1'b1;
    end
    tx_drop = (state_q == ST_ACK) && drop_q;
  end

  assign rx_valid      = rx_valid_q;
  assign rx_byte       = rx_byte_q;
  assign tx_busy       = (state_q == ST_S_ADDR) || (state_q == ST_S_DATA) ||
                         (state_q == ST_W_ADDR) || (state_q == ST_W_DATA);
  assign unused_hrdata = ^{HRDATA[31:8], arb_ptr};

  // A granted requester keeps tx_req high until its tx_ack.
  tx_req_held_a: assert property (@(posedge HCLK) disable iff (HRESET)
    tx_busy |-> tx_req[grant_q]);

endmodule

// File: tb/tb_ahb_uart_access_sched.sv
// Directed bench for ahb_uart_access_sched: a small AHB UART slave model logs
// every completed transfer, requesters re-raise tx_req until their byte goal is met.
module tb_ahb_uart_access_sched;

  localparam logic [31:0] DATA_ADDR = 32'h5100_0000;
  localparam logic [31:0] STAT_ADDR = 32'h5100_0004;
  localparam logic [7:0]  EV_R      = 8'h52;
  localparam logic [7:0]  EV_W      = 8'h57;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  tx_req = 2'b00;
  logic [7:0]  tx_byte0 = 8'h00;
  logic [7:0]  tx_byte1 = 8'h00;
  logic [1:0]  tx_ack;
  logic        tx_drop;
  logic        uart_irq;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  int tests_run = 0;
  int tests_failed = 0;

  // slave model state
  logic        dp_act = 1'b0;
  logic        dp_wr = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  int          stat_cnt = 0, full_until = 0, rd_cnt = 0, irq_raise = 0;
  int          stall_cyc = 0, stall_until = 0, stall_bad = 0;
  logic [7:0]  stall_byte = 8'h00;
  logic [31:0] rx_word = 32'h0;
  logic        stat_full;
  logic [47:0] ev_q[$];
  int          cyc = 0;

  // requester / observer state
  int          req_goal[2] = '{0, 0};
  int          ack_cnt[2] = '{0, 0};
  int          rise_cyc[2] = '{0, 0};
  int          lat[2] = '{0, 0};
  int          drop_cnt = 0, rx_cnt = 0;
  logic [7:0]  rx_last = 8'h00;
  int          ack_order[$];
  logic [7:0]  exp_q[$];

  ahb_uart_access_sched #(.MAX_POLLS(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .tx_req(tx_req), .tx_byte0(tx_byte0), .tx_byte1(tx_byte1),
    .tx_ack(tx_ack), .tx_drop(tx_drop),
    .uart_irq(uart_irq), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  assign stat_full = (stat_cnt < full_until);
  assign uart_irq  = (irq_raise != rd_cnt);
  assign HREADYOUT = !(dp_act && dp_wr && (stall_cyc < stall_until));
  assign HRDATA    = !dp_act ? 32'h0 :
                     (dp_addr == STAT_ADDR) ? {30'h0, !uart_irq, stat_full} : rx_word;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_act <= 1'b0;
      dp_wr  <= 1'b0;
    end else begin
      if (dp_act && HREADYOUT) begin
        dp_act <= 1'b0;
        if (dp_wr) begin
          ev_q.push_back({EV_W, dp_addr, HWDATA[7:0]});
        end else begin
          ev_q.push_back({EV_R, dp_addr, HRDATA[7:0]});
          if (dp_addr == STAT_ADDR) stat_cnt <= stat_cnt + 1;
          else rd_cnt <= rd_cnt + 1;
        end
      end
      if (dp_act && !HREADYOUT) begin
        stall_cyc <= stall_cyc + 1;
        if (HWDATA !== {24'h0, stall_byte} || HTRANS === 2'b10) stall_bad <= stall_bad + 1;
      end
      if (HTRANS == 2'b10 && HREADYOUT) begin
        dp_act  <= 1'b1;
        dp_wr   <= HWRITE;
        dp_addr <= HADDR;
      end
    end
  end

  always @(negedge HCLK) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_last = rx_byte;
    end
    for (int i = 0; i < 2; i++) begin
      if (tx_ack[i]) begin
        tx_req[i] = 1'b0;
        ack_cnt[i]++;
        lat[i] = cyc - rise_cyc[i];
        ack_order.push_back(i);
        if (tx_drop) drop_cnt++;
      end else if (!tx_req[i] && ack_cnt[i] < req_goal[i]) begin
        tx_req[i]   = 1'b1;
        rise_cyc[i] = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
    #1;
  endtask

  task automatic wait_for_acks(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge HCLK);
      #1;
      if (ack_cnt[0] + ack_cnt[1] >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    idle(2);
    tests_run++;
    if ({HSEL, HTRANS, HADDR, HWRITE, HWDATA, tx_ack, tx_drop, rx_valid, rx_byte} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got htrans=%0h haddr=%0h hwdata=%0h ack=%0h rx=%0h want all 0",
               HTRANS, HADDR, HWDATA, tx_ack, rx_byte);
    end
    HRESET = 1'b0;
    idle(2);
    tests_run++;
    if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_bus: got htrans=%0h hsel=%0b want 0/0", HTRANS, HSEL);
    end
  endtask

  task automatic test_round_robin;
    int base, abase, k;
    bit ok;
    base  = ev_q.size();
    abase = ack_order.size();
    tx_byte0 = 8'h11;
    tx_byte1 = 8'h22;
    exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
    req_goal[0] += 2;
    req_goal[1] += 2;
    wait_for_acks(4, 80, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rr_timeout: got %0d acks want 4", ack_cnt[0] + ack_cnt[1]);
    end
    k = 0;
    for (int i = base; i < ev_q.size(); i++) begin
      if (ev_q[i][47:40] == EV_W) begin
        tests_run++;
        if (k >= 4 || ev_q[i][7:0] !== exp_q[k] || ev_q[i][39:8] !== DATA_ADDR) begin
          tests_failed++;
          $display("FAIL rr_write_%0d: got addr=%0h byte=%0h want addr=%0h byte=%0h",
                   k, ev_q[i][39:8], ev_q[i][7:0], DATA_ADDR, (k < 4) ? exp_q[k] : 8'hxx);
        end
        k++;
      end
    end
    tests_run++;
    if (k != 4) begin
      tests_failed++;
      $display("FAIL rr_write_count: got %0d want 4", k);
    end
    tests_run++;
    if (ack_order.size() - abase != 4 || ack_order[abase] != 0 || ack_order[abase+1] != 1 ||
        ack_order[abase+2] != 0 || ack_order[abase+3] != 1) begin
      tests_failed++;
      $display("FAIL rr_ack_order: got %0d acks, first=%0d want 4 acks 0,1,0,1",
               ack_order.size() - abase, ack_order[abase]);
    end
    idle(3);
  endtask

  task automatic test_single;
    int base, a0;
    bit ok;
    base = ev_q.size();
    a0   = ack_cnt[0];
    tx_byte0 = 8'h41;
    req_goal[0] += 1;
    wait_for_acks(ack_cnt[0] + ack_cnt[1] + 1, 40, ok);
    tests_run++;
    if (!ok || ack_cnt[0] != a0 + 1) begin
      tests_failed++;
      $display("FAIL single_ack: got %0d acks on req0 want %0d", ack_cnt[0], a0 + 1);
    end
    // request cycle counts as cycle 1, so ack in cycle 6 is five edges later
    tests_run++;
    if (lat[0] != 5) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d edges want 5", lat[0]);
    end
    tests_run++;
    if (ev_q.size() - base != 2 || ev_q[base] !== {EV_R, STAT_ADDR, 8'h02} ||
        ev_q[base+1] !== {EV_W, DATA_ADDR, 8'h41}) begin
      tests_failed++;
      $display("FAIL single_bus: got %0d transfers first=%0h want 2 (status read, write 41)",
               ev_q.size() - base, ev_q[base]);
    end
    idle(3);
  endtask

  task automatic test_poll;
    int base, d0;
    bit ok;
    base = ev_q.size();
    d0   = drop_cnt;
    full_until = stat_cnt + 3;
    tx_byte0 = 8'h5E;
    req_goal[0] += 1;
    wait_for_acks(ack_cnt[0] + ack_cnt[1] + 1, 60, ok);
    tests_run++;
    if (!ok || lat[0] != 11) begin
      tests_failed++;
      $display("FAIL poll_latency: got ok=%0b lat=%0d want lat 11", ok, lat[0]);
    end
    tests_run++;
    if (ev_q.size() - base != 5 || ev_q[base] !== {EV_R, STAT_ADDR, 8'h03} ||
        ev_q[base+2] !== {EV_R, STAT_ADDR, 8'h03} || ev_q[base+3] !== {EV_R, STAT_ADDR, 8'h02} ||
        ev_q[base+4] !== {EV_W, DATA_ADDR, 8'h5E}) begin
      tests_failed++;
      $display("FAIL poll_bus: got %0d transfers last=%0h want 5 (4 status reads, write 5e)",
               ev_q.size() - base, ev_q[ev_q.size()-1]);
    end
    tests_run++;
    if (drop_cnt != d0) begin
      tests_failed++;
      $display("FAIL poll_no_drop: got %0d drops want %0d", drop_cnt, d0);
    end
    idle(3);
  endtask

  task automatic test_poll_drop;
    int base, d0, a1;
    bit ok;
    base = ev_q.size();
    d0   = drop_cnt;
    a1   = ack_cnt[1];
    full_until = stat_cnt + 1000;
    tx_byte1 = 8'h77;
    req_goal[1] += 1;
    wait_for_acks(ack_cnt[0] + ack_cnt[1] + 1, 60, ok);
    full_until = stat_cnt;
    tests_run++;
    if (!ok || ack_cnt[1] != a1 + 1 || lat[1] != 9) begin
      tests_failed++;
      $display("FAIL drop_ack: got ok=%0b acks1=%0d lat=%0d want acks1=%0d lat=9",
               ok, ack_cnt[1], lat[1], a1 + 1);
    end
    tests_run++;
    if (drop_cnt != d0 + 1) begin
      tests_failed++;
      $display("FAIL drop_flag: got %0d drops want %0d", drop_cnt, d0 + 1);
    end
    tests_run++;
    if (ev_q.size() - base != 4 || ev_q[base+3] !== {EV_R, STAT_ADDR, 8'h03}) begin
      tests_failed++;
      $display("FAIL drop_bus: got %0d transfers last=%0h want 4 status reads, no write",
               ev_q.size() - base, ev_q[ev_q.size()-1]);
    end
    idle(3);
  endtask

  task automatic test_rx_during_tx;
    int base, r0;
    bit ok;
    base = ev_q.size();
    r0   = rx_cnt;
    tx_byte0 = 8'h33;
    req_goal[0] += 1;
    idle(2);
    rx_word = 32'h0000_005A;
    irq_raise++;
    wait_for_acks(ack_cnt[0] + ack_cnt[1] + 1, 40, ok);
    for (int i = 0; i < 20 && rx_cnt == r0; i++) idle(1);
    idle(4);
    tests_run++;
    if (!ok || rx_cnt != r0 + 1) begin
      tests_failed++;
      $display("FAIL rx_pulse_count: got ack_ok=%0b rx pulses=%0d want 1", ok, rx_cnt - r0);
    end
    tests_run++;
    if (rx_last !== 8'h5A || rx_byte !== 8'h5A) begin
      tests_failed++;
      $display("FAIL rx_byte: got %0h (held %0h) want 5a", rx_last, rx_byte);
    end
    tests_run++;
    if (ev_q.size() - base != 3 || ev_q[base] !== {EV_R, STAT_ADDR, 8'h00} ||
        ev_q[base+1] !== {EV_W, DATA_ADDR, 8'h33} || ev_q[base+2] !== {EV_R, DATA_ADDR, 8'h5A}) begin
      tests_failed++;
      $display("FAIL rx_order: got %0d transfers second=%0h want status, write 33, data read 5a",
               ev_q.size() - base, ev_q[base+1]);
    end
    idle(2);
  endtask

  task automatic test_stall;
    int base, sb, sc;
    bit ok;
    base = ev_q.size();
    sb   = stall_bad;
    sc   = stall_cyc;
    tx_byte0    = 8'h5C;
    stall_byte  = 8'h5C;
    stall_until = stall_cyc + 3;
    req_goal[0] += 1;
    wait_for_acks(ack_cnt[0] + ack_cnt[1] + 1, 40, ok);
    tests_run++;
    if (!ok || lat[0] != 8) begin
      tests_failed++;
      $display("FAIL stall_latency: got ok=%0b lat=%0d want lat 8", ok, lat[0]);
    end
    tests_run++;
    if (stall_cyc - sc != 3 || stall_bad != sb) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d stall cycles, %0d bad want 3 stall cycles, 0 bad",
               stall_cyc - sc, stall_bad - sb);
    end
    tests_run++;
    if (ev_q.size() - base != 2 || ev_q[base+1] !== {EV_W, DATA_ADDR, 8'h5C}) begin
      tests_failed++;
      $display("FAIL stall_bus: got %0d transfers last=%0h want status read, write 5c",
               ev_q.size() - base, ev_q[ev_q.size()-1]);
    end
    idle(3);
  endtask

  task automatic test_reset_mid;
    int base, a0;
    bit found, ok;
    base = ev_q.size();
    a0   = ack_cnt[0];
    tx_byte0 = 8'h6E;
    req_goal[0] += 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (dp_act && dp_wr) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL rst_reach_wdata: got no write data phase want one within 20 cycles");
    end
    HRESET = 1'b1;
    #1;
    tests_run++;
    if ({HSEL, HTRANS, HADDR, HWRITE, HWDATA, tx_ack, tx_drop} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got htrans=%0h hwdata=%0h ack=%0h want all 0",
               HTRANS, HWDATA, tx_ack);
    end
    idle(2);
    HRESET = 1'b0;
    tests_run++;
    if (ack_cnt[0] != a0) begin
      tests_failed++;
      $display("FAIL rst_no_ack: got %0d acks want %0d", ack_cnt[0], a0);
    end
    wait_for_acks(ack_cnt[0] + ack_cnt[1] + 1, 40, ok);
    idle(3);
    tests_run++;
    if (!ok || ack_cnt[0] != a0 + 1) begin
      tests_failed++;
      $display("FAIL rst_regrant: got %0d acks want %0d", ack_cnt[0], a0 + 1);
    end
    tests_run++;
    if (ev_q.size() - base != 3 || ev_q[base+1] !== {EV_R, STAT_ADDR, 8'h02} ||
        ev_q[base+2] !== {EV_W, DATA_ADDR, 8'h6E}) begin
      tests_failed++;
      $display("FAIL rst_bus: got %0d transfers last=%0h want status, status, write 6e",
               ev_q.size() - base, ev_q[ev_q.size()-1]);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_poll;
    test_poll_drop;
    test_rx_during_tx;
    test_stall;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
